// File: rtl/dmem_wait_model.sv
// Byte-addressed data memory slave with programmable wait states,
// out-of-range / misaligned error responses and a side-band debug read port.
module dmem_wait_model #(
  parameter int unsigned MEM_BYTES    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter bit          MISALIGN_ERR = 1'b1,
  parameter bit          INIT_MODE    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_mem,
  input  logic        wmem_o,
  input  logic [3:0]  wmask,
  input  logic [31:0] addr_o,
  input  logic [31:0] data_o,
  output logic [31:0] data_i,
  output logic        data_stall,
  output logic        data_err,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam logic [32:0] MEM_SIZE = 33'(MEM_BYTES);
  localparam logic [3:0]  WAIT_N   = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mem_q [MEM_BYTES];

  logic [31:0]   off;
  logic [1:0]    hi_lane;
  logic          any_acc;
  logic [32:0]   last_byte;
  logic          out_rng;
  logic          mis;
  logic          bad;
  logic          done;
  logic          wr_en;
  logic [32:0]   rd_idx  [4];
  logic [7:0]    rd_byte [4];
  logic [AW-1:0] wr_idx  [4];
  logic [31:0]   dbg_off;
  logic [32:0]   dbg_idx  [4];
  logic [7:0]    dbg_byte [4];

  // Access decode: offset, highest touched lane and the error condition.
  // The range test uses 33-bit arithmetic so offsets near 2^32 never wrap back in.
  always_comb begin
    off = addr_o - BASE_ADDR;
    if (wmem_o) begin
      any_acc = |wmask;
      if (wmask[3])      hi_lane = 2'd3;
      else if (wmask[2]) hi_lane = 2'd2;
      else if (wmask[1]) hi_lane = 2'd1;
      else               hi_lane = 2'd0;
    end else begin
      any_acc = 1'b1;
      hi_lane = 2'd3;
    end
    last_byte = {1'b0, off} + {31'b0, hi_lane};
    out_rng   = any_acc && (last_byte >= MEM_SIZE);
    mis       = MISALIGN_ERR && any_acc && (({1'b0, off[1:0]} + {1'b0, hi_lane}) > 3'd3);
    bad       = out_rng || mis;
  end

  // Core read data and write lane addresses; out-of-range bytes read as zero.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      rd_idx[k]  = {1'b0, off} + 33'(k);
      rd_byte[k] = (rd_idx[k] < MEM_SIZE) ? mem_q[rd_idx[k][AW-1:0]] : '0;
      wr_idx[k]  = off[AW-1:0] + AW'(k);
    end
    data_i = bad ? '0 : {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
  end

  // Debug read port, independent of core traffic.
  always_comb begin
    dbg_off = dbg_addr - BASE_ADDR;
    for (int unsigned k = 0; k < 4; k++) begin
      dbg_idx[k]  = {1'b0, dbg_off} + 33'(k);
      dbg_byte[k] = (dbg_idx[k] < MEM_SIZE) ? mem_q[dbg_idx[k][AW-1:0]] : '0;
    end
    dbg_rdata = {dbg_byte[3], dbg_byte[2], dbg_byte[1], dbg_byte[0]};
  end

  // Wait-state sequencing: stall until cnt reaches WAIT_CYCLES, then complete.
  // Outputs are held quiet while reset is asserted so an abandoned access never reports.
  always_comb begin
    done       = req_mem && !reset && (cnt_q == WAIT_N);
    data_stall = req_mem && !reset && (cnt_q != WAIT_N);
    data_err   = done && bad;
    wr_en      = done && wmem_o && !bad;
    if (data_stall) cnt_d = (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
    else            cnt_d = '0;
    state_d = (cnt_d != '0) ? WAIT : IDLE;
  end

  // State, counter and memory array; reset reinitialises the whole array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < MEM_BYTES; i++)
        mem_q[i] <= INIT_MODE ? 8'h00 : 8'(i);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_en) begin
        for (int unsigned k = 0; k < 4; k++)
          if (wmask[k]) mem_q[wr_idx[k]] <= data_o[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_model.sv
// Scoreboard bench for dmem_wait_model: three instances with different
// wait/misalign settings, directed vectors with hand-computed expectations.
module tb_dmem_wait_model;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic        wmem  [3];
  logic [3:0]  wm    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rd    [3];
  logic        stall [3];
  logic        err   [3];
  logic [31:0] dbga  [3];
  logic [31:0] dbgd  [3];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    bit          we;
    logic [31:0] rd;
    bit          er;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   scnt [3];

  // u0: 0 waits, misalign errors; u1: 3 waits, misalign allowed; u2: 4 waits, misalign errors
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_wait_model #(
      .MEM_BYTES   (4096),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 4)),
      .MISALIGN_ERR(g == 1 ? 1'b0 : 1'b1),
      .INIT_MODE   (1'b0)
    ) u_dut (
      .clk       (clk),
      .reset     (rst),
      .req_mem   (req[g]),
      .wmem_o    (wmem[g]),
      .wmask     (wm[g]),
      .addr_o    (addr[g]),
      .data_o    (wd[g]),
      .data_i    (rd[g]),
      .data_stall(stall[g]),
      .data_err  (err[g]),
      .dbg_addr  (dbga[g]),
      .dbg_rdata (dbgd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles per instance and scores every completion.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst || !req[i]) begin
        scnt[i] = 0;
      end else if (stall[i]) begin
        scnt[i]++;
        chk($sformatf("err_during_stall u%0d", i), {31'b0, err[i]}, 32'd0);
      end else begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_completion u%0d", i), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("completion_inst u%0d", i), i, e.inst);
          chk($sformatf("stall_cycles u%0d", i), scnt[i], e.waits);
          chk($sformatf("data_err u%0d", i), {31'b0, err[i]}, {31'b0, e.er});
          if (!e.we) chk($sformatf("data_i u%0d", i), rd[i], e.rd);
        end
        scnt[i] = 0;
      end
    end
  end

  // Issue one access, push its expectation, wait (bounded) for completion.
  task automatic issue(input int i, input bit we, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input bit exp_er);
    int n;
    sb.push_back('{inst: i, we: we, rd: exp_rd, er: exp_er, waits: waits_of(i)});
    req[i] = 1'b1; wmem[i] = we; wm[i] = m; addr[i] = a; wd[i] = d;
    n = 0;
    @(negedge clk);
    while (stall[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (stall[i]) begin
      chk($sformatf("completion_timeout u%0d", i), 32'd1, 32'd0);
      void'(sb.pop_back());
    end
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  task automatic dbg(input int i, input logic [31:0] a, input logic [31:0] exp);
    dbga[i] = a;
    #1 chk($sformatf("dbg u%0d @%h", i, a), dbgd[i], exp);
  endtask

  // Start a write, let cnt reach 2, then abandon it by dropping req or by reset.
  task automatic abandon(input int i, input logic [31:0] a, input logic [31:0] d, input bit use_rst);
    req[i] = 1'b1; wmem[i] = 1'b1; wm[i] = 4'hF; addr[i] = a; wd[i] = d;
    repeat (2) @(posedge clk);
    #1 chk($sformatf("stall_at_cnt2 u%0d", i), {31'b0, stall[i]}, 32'd1);
    if (use_rst) begin
      rst = 1'b1;
      #1 chk($sformatf("stall_in_reset u%0d", i), {31'b0, stall[i]}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      req[i] = 1'b0;
    end else begin
      req[i] = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; wmem[i] = 1'b0; wm[i] = 4'h0; addr[i] = 32'h10; wd[i] = '0; dbga[i] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_stall u%0d", i), {31'b0, stall[i]}, 32'd0);
      chk($sformatf("reset_err u%0d", i), {31'b0, err[i]}, 32'd0);
    end
    chk("reset_data_i u0", rd[0], 32'h13121110);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;

    dbg(2, 32'hFFC, 32'hFFFEFDFC);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h13121110, 1'b0);
    issue(1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0);
    dbg(1, 32'h20, 32'hDEADBEEF);
    issue(0, 1'b1, 4'b0010, 32'h41, 32'h0000AB00, 32'h0, 1'b0);
    dbg(0, 32'h40, 32'h43AB4140);
    issue(0, 1'b1, 4'b0011, 32'h43, 32'h0000FFFF, 32'h0, 1'b1);
    dbg(0, 32'h40, 32'h43AB4140);
    issue(0, 1'b0, 4'h0, 32'h102, 32'h0, 32'h0, 1'b1);
    issue(1, 1'b0, 4'h0, 32'h102, 32'h0, 32'h05040302, 1'b0);
    issue(1, 1'b1, 4'hF, 32'hFFE, 32'h12345678, 32'h0, 1'b1);
    dbg(1, 32'hFFC, 32'hFFFEFDFC);
    issue(1, 1'b0, 4'h0, 32'hFFC, 32'h0, 32'hFFFEFDFC, 1'b0);
    issue(0, 1'b0, 4'h0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 4'h0, 32'h2000, 32'h55, 32'h0, 1'b0);
    issue(0, 1'b1, 4'hF, 32'h80, 32'h11223344, 32'h0, 1'b0);
    issue(0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h11223344, 1'b0);
    issue(1, 1'b1, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0);
    issue(1, 1'b0, 4'h0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0);

    abandon(2, 32'h60, 32'hCAFEF00D, 1'b0);
    dbg(2, 32'h60, 32'h63626160);
    issue(2, 1'b1, 4'hF, 32'h60, 32'hCAFEF00D, 32'h0, 1'b0);
    dbg(2, 32'h60, 32'hCAFEF00D);
    abandon(2, 32'h64, 32'h0BADF00D, 1'b1);
    dbg(2, 32'h64, 32'h67666564);
    dbg(2, 32'h60, 32'h63626160);
    dbg(1, 32'h20, 32'h23222120);
    issue(2, 1'b1, 4'hF, 32'h64, 32'h0BADF00D, 32'h0, 1'b0);
    dbg(2, 32'h64, 32'h0BADF00D);

    @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_wait_model.md
Name: dmem_wait_model

Overview:
- Parametrised byte-addressed data memory slave for the RV32I core bench and FPGA smoke builds.
- Successor to the fixed 4 KiB zero-latency bench memory.
- Adds configurable size and base address, programmable wait states that drive the core's data_stall, and error responses for out-of-range and misaligned accesses.
- Adds a side-band debug read port so bench checkers can inspect memory without disturbing the core.

Parameters:
- MEM_BYTES, 4096: memory size in bytes; power of two, minimum 8.
- BASE_ADDR, 32'h0000_0000: address of byte 0; must be aligned to MEM_BYTES.
- WAIT_CYCLES, 0: stall cycles inserted before every access completes; 0 to 15.
- MISALIGN_ERR, 1: 1 = accesses crossing a 4-byte boundary return err; 0 = allowed.
- INIT_MODE, 0: reset contents. 0 = byte i holds i[7:0]; 1 = all zero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_mem  in  1  access request from core; held stable while data_stall=1
- wmem_o  in  1  1 = write, 0 = read
- wmask  in  4  write byte lanes; lane k writes byte addr_o+k
- addr_o  in  32  byte address
- data_o  in  32  write data; lane k = bits [8k+7:8k]
- data_i  out  32  read data
- data_stall  out  1  access not yet complete
- data_err  out  1  access completed with error
- dbg_addr  in  32  debug byte address
- dbg_rdata  out  32  debug word {mem[a+3],mem[a+2],mem[a+1],mem[a]}, combinational, out-of-range bytes read 0

Behaviour:
- Only clk and reset are named as in the core; this block has one clock, and reset is synchronous and active-high.
- Reset (clock edge with reset=1):
  - cnt=0, state IDLE.
  - Memory rewritten per INIT_MODE in that same edge.
  - Outputs during and after reset: data_stall=0, data_err=0, data_i per the read rule.
  - Reset mid-wait abandons the access; no write occurs.
- Offset: off = addr_o - BASE_ADDR (32-bit unsigned).
- Accessed bytes:
  - Read: bytes off..off+3.
  - Write: bytes off+k for each set wmask[k].
- Error condition bad (combinational), true if either holds:
  - Any accessed byte is >= MEM_BYTES. No wrap-around; off near 2^32 counts as out of range.
  - MISALIGN_ERR=1 and off[1:0] + (highest accessed lane) > 3.
- Write with wmask=0: no-op, completes normally with no error.
- Wait counter cnt, 4 bits; states IDLE (cnt=0) and WAIT (cnt>0).
  - data_stall = req_mem & (cnt != WAIT_CYCLES), combinational.
  - While req_mem & data_stall, cnt increments each edge (IDLE -> WAIT on the first edge).
  - Completion cycle: req_mem=1 and cnt==WAIT_CYCLES, so data_stall=0. The next edge returns cnt to 0.
  - A new request needs the full wait again, including back-to-back requests.
  - With WAIT_CYCLES=0 every request completes in its first cycle, matching the legacy bench memory.
  - req_mem dropping while cnt>0 returns cnt to 0 next edge; the access is abandoned.
- Completion cycle outputs:
  - data_err = bad.
  - Write and !bad: enabled bytes commit at the closing edge.
  - Write and bad: nothing written.
- data_err = 0 in every non-completion cycle.
- data_i is combinational and always valid when !bad:
  - {mem[off+3],mem[off+2],mem[off+1],mem[off]}.
  - When bad, data_i = 0.
  - The core samples data_i only in the completion cycle.
- Write-then-read in consecutive completions: the read sees new data, since the write committed at the prior edge.
- dbg port is independent of core traffic. A dbg read of an address being written in the same cycle returns pre-write data.
- wmem_o, wmask, addr_o, data_o changing while data_stall=1 is a protocol violation. The block samples them in the completion cycle only.

Test Plan:
- Reset, INIT_MODE=0, WAIT_CYCLES=0; read addr 0x10 -> data_i=32'h13121110, data_stall=0, data_err=0 same cycle.
- WAIT_CYCLES=3; write addr 0x20, data 0xDEADBEEF, wmask 4'b1111, req held -> data_stall high exactly 3 cycles, 4th cycle completes; then dbg_addr=0x20 reads 0xDEADBEEF.
- WAIT_CYCLES=0; write addr 0x41, data 0x0000AB00, wmask 4'b0010 -> only byte 0x42 becomes 0xAB; dbg word at 0x40 = 0x43AB4140.
- MISALIGN_ERR=1; read addr 0x102 -> data_err=1, data_i=0. With MISALIGN_ERR=0 -> data_err=0, data_i=0x05040302.
- MEM_BYTES=4096; write addr 0xFFE, wmask 4'b1111, MISALIGN_ERR=0 -> data_err=1, bytes 0xFFE/0xFFF unchanged (0xFE/0xFF).
- WAIT_CYCLES=4; req_mem dropped after 2 stall cycles, or reset asserted at cnt=2 -> no write, cnt=0. A re-issued request stalls a full 4 cycles again.
